// File: rtl/fifo_wr_rr_arbiter_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the round-robin FIFO write arbiter:
//   - state_e  : arbiter FSM encoding (ST_IDLE, ST_BURST), 2 bits wide
//   - id_w()   : width of a producer index, never less than 1 bit
//   - cnt_w()  : width of the beat counter for a given MAX_BURST
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01
  } state_e;

  function automatic int id_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int cnt_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_rr_arbiter_rr_pick.sv
// rr_pick
//   Combinational rotate-priority search: returns the first set bit of req
//   starting at position ptr and wrapping past N_REQ-1 back to 0.
//   Ports:
//     req [N_REQ]  request vector
//     ptr [ID_W]   starting search position (0 .. N_REQ-1)
//     any          at least one request is set
//     idx [ID_W]   index of the winning request (0 when any==0)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic [ID_W-1:0] cand;

  // Walk all N_REQ positions from ptr; the wrap is an explicit compare so
  // non-power-of-two N_REQ never visits an out-of-range index.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
      cand = (cand == LAST_ID) ? '0 : cand + ID_W'(1);
    end
  end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// fifo_wr_rr_arbiter
//   Shares one FIFO write port among N_REQ valid/ready producers. A producer
//   is granted for a burst of up to MAX_BURST beats; grants rotate round-robin.
//   Every grant costs one arbitration cycle in IDLE during which no beat moves.
//   Ports:
//     clk, reset_n   clock; asynchronous active-low reset
//     req_valid      per-producer beat available
//     req_data       producer i beat at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready      per-producer beat accepted this cycle
//     fifo_wr_ready  FIFO can take a write
//     fifo_wr_en     write strobe (only ever high with fifo_wr_ready)
//     fifo_wr_data   write data
//     fifo_wr_src    index of the granted producer
//     busy           arbiter is in a burst
module fifo_wr_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = id_w(N_REQ),
  localparam int CNT_W      = cnt_w(MAX_BURST)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_wr_ready,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  output logic [ID_W-1:0]             fifo_wr_src,
  output logic                        busy
);

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_e           state_q,    state_d;
  logic [ID_W-1:0]  gnt_id_q,   gnt_id_d;
  logic [ID_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;
  logic             gnt_valid;
  logic             beat;
  logic [ID_W-1:0]  ptr_after_gnt;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign busy          = (state_q == ST_BURST);
  assign gnt_valid     = req_valid[gnt_id_q];
  assign beat          = busy && gnt_valid && fifo_wr_ready;
  assign ptr_after_gnt = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + ID_W'(1);

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_BURST;
          gnt_id_d   = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (!gnt_valid) begin
          // Producer withdrew: end the grant without moving a beat.
          state_d    = ST_IDLE;
          rr_ptr_d   = ptr_after_gnt;
          beat_cnt_d = '0;
        end else if (fifo_wr_ready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = ptr_after_gnt;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
        // valid but FIFO full: hold grant and count
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Output mux: everything is gated by busy so reset (which forces IDLE)
  // drives all outputs to zero immediately.
  always_comb begin
    fifo_wr_data = '0;
    req_ready    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (busy && (gnt_id_q == ID_W'(i))) begin
        fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = fifo_wr_ready;
      end
    end
  end

  assign fifo_wr_en  = beat;
  assign fifo_wr_src = busy ? gnt_id_q : '0;

endmodule
